// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO that feeds uart_tx one frame at a time
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [7:0]            i_wr_byte,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_tx_byte_rdy,
    output logic [7:0]            o_tx_byte,
    input  logic                  i_tx_done,
    output logic                  o_busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  busy_q, busy_d;
    logic                  tx_byte_rdy_q, tx_byte_rdy_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic                  push;
    logic                  pop;

    always_comb begin
        // Acceptance uses the registered full flag, so a same-cycle pop never rescues a push.
        push          = i_wr_en && !full_q;
        pop           = (state_q == ST_IDLE) && (count_q != '0);
        state_d       = state_q;
        tx_byte_rdy_d = 1'b0;
        tx_byte_d     = tx_byte_q;

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d       = ST_ISSUE;
                    tx_byte_rdy_d = 1'b1;
                    tx_byte_d     = mem_q[rd_ptr_q];
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_tx_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        full_d     = (count_d == FULL_COUNT);
        empty_d    = (count_d == '0);
        overflow_d = i_wr_en && full_q;
        busy_d     = (state_q != ST_IDLE) || (count_q != '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            overflow_q    <= 1'b0;
            busy_q        <= 1'b0;
            tx_byte_rdy_q <= 1'b0;
            tx_byte_q     <= 8'h00;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            overflow_q    <= overflow_d;
            busy_q        <= busy_d;
            tx_byte_rdy_q <= tx_byte_rdy_d;
            tx_byte_q     <= tx_byte_d;
        end
    end

    // Storage is deliberately left uninitialised on reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && push) begin
            mem_q[wr_ptr_q] <= i_wr_byte;
        end
    end

    assign o_full        = full_q;
    assign o_empty       = empty_q;
    assign o_count       = count_q;
    assign o_overflow    = overflow_q;
    assign o_tx_byte_rdy = tx_byte_rdy_q;
    assign o_tx_byte     = tx_byte_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;

    logic                clk = 1'b0;
    logic                i_rst;
    logic                i_wr_en;
    logic [7:0]          i_wr_byte;
    logic                i_tx_done;
    logic                o_full;
    logic                o_empty;
    logic [DEPTH_LOG2:0] o_count;
    logic                o_overflow;
    logic                o_tx_byte_rdy;
    logic [7:0]          o_tx_byte;
    logic                o_busy;

    int checks   = 0;
    int failures = 0;

    // reference model: queue of accepted bytes plus a frame-in-flight flag
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         m_count  = 0;
    bit         m_active = 1'b0;
    bit         m_issue  = 1'b0;
    bit         mon_en   = 1'b0;
    logic [7:0] e_byte   = 8'h00;
    bit         e_rdy, e_ovf, e_busy;
    int         coin_cnt = 0;

    // uart_tx stand-in
    int done_cnt   = 0;
    bit hold_done  = 1'b0;
    bit stray_done = 1'b0;
    int frame_lo   = 2;
    int frame_hi   = 5;

    uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_wr_en       (i_wr_en),
        .i_wr_byte     (i_wr_byte),
        .o_full        (o_full),
        .o_empty       (o_empty),
        .o_count       (o_count),
        .o_overflow    (o_overflow),
        .o_tx_byte_rdy (o_tx_byte_rdy),
        .o_tx_byte     (o_tx_byte),
        .i_tx_done     (i_tx_done),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        i_tx_done = 1'b0;
        forever begin
            bit fire;
            @(negedge clk);
            fire = 1'b0;
            if (done_cnt > 0 && !hold_done) begin
                done_cnt--;
                if (done_cnt == 0) fire = 1'b1;
            end
            if (o_tx_byte_rdy === 1'b1) done_cnt = $urandom_range(frame_hi, frame_lo);
            i_tx_done = fire | stray_done;
        end
    end

    always @(posedge clk) begin : monitor
        int pre_count;
        bit pre_active, pre_issue, push_ok;
        #1;
        pre_count  = m_count;
        pre_active = m_active;
        pre_issue  = m_issue;
        if (i_rst === 1'b1) begin
            exp_q.delete();
            m_count  = 0;
            m_active = 1'b0;
            m_issue  = 1'b0;
            e_byte   = 8'h00;
            e_rdy    = 1'b0;
            e_ovf    = 1'b0;
            e_busy   = 1'b0;
            mon_en   = 1'b1;
        end else begin
            e_busy  = pre_active || (pre_count != 0);
            e_ovf   = i_wr_en && (pre_count == DEPTH);
            push_ok = i_wr_en && (pre_count != DEPTH);
            e_rdy   = !pre_active && (pre_count != 0);
            if (e_rdy) e_byte = exp_q.pop_front();
            if (push_ok) exp_q.push_back(i_wr_byte);
            m_count = pre_count + (push_ok ? 1 : 0) - (e_rdy ? 1 : 0);
            if (push_ok && e_rdy) coin_cnt++;
            if (pre_active && !pre_issue && i_tx_done) m_active = 1'b0;
            m_issue = 1'b0;
            if (e_rdy) begin
                m_active = 1'b1;
                m_issue  = 1'b1;
            end
        end
        if (o_tx_byte_rdy === 1'b1) rx_q.push_back(o_tx_byte);
        if (mon_en) begin
            checks++;
            if (o_count !== 5'(m_count)) begin
                failures++;
                $display("FAIL mon_count t=%0t actual=%0d required=%0d", $time, o_count, m_count);
            end
            checks++;
            if ({o_full, o_empty} !== {m_count == DEPTH, m_count == 0}) begin
                failures++;
                $display("FAIL mon_full_empty t=%0t actual=%b%b required=%b%b", $time,
                         o_full, o_empty, m_count == DEPTH, m_count == 0);
            end
            checks++;
            if (o_overflow !== e_ovf) begin
                failures++;
                $display("FAIL mon_overflow t=%0t actual=%b required=%b", $time, o_overflow, e_ovf);
            end
            checks++;
            if (o_tx_byte_rdy !== e_rdy) begin
                failures++;
                $display("FAIL mon_rdy t=%0t actual=%b required=%b", $time, o_tx_byte_rdy, e_rdy);
            end
            checks++;
            if (o_tx_byte !== e_byte) begin
                failures++;
                $display("FAIL mon_tx_byte t=%0t actual=%h required=%h", $time, o_tx_byte, e_byte);
            end
            checks++;
            if (o_busy !== e_busy) begin
                failures++;
                $display("FAIL mon_busy t=%0t actual=%b required=%b", $time, o_busy, e_busy);
            end
        end
    end

    task automatic wait_quiet(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (o_busy === 1'b0 && done_cnt == 0 && i_tx_done === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_wr_en = 1'b0; i_wr_byte = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({o_tx_byte_rdy, o_tx_byte, o_overflow, o_full, o_empty, o_count, o_busy} !==
                {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0}) begin
                failures++;
                $display("FAIL reset_state cyc=%0d actual=%b/%h/%b/%b/%b/%0d/%b required=0/00/0/0/1/0/0",
                         i, o_tx_byte_rdy, o_tx_byte, o_overflow, o_full, o_empty, o_count, o_busy);
            end
        end
    endtask

    task automatic test_single();
        bit ok;
        rx_q.delete();
        frame_lo = 3; frame_hi = 6;
        @(negedge clk);
        i_wr_en = 1'b1; i_wr_byte = 8'hAB;
        @(posedge clk);
        #1;
        checks++;
        if (o_count !== 5'd1 || o_empty !== 1'b0 || o_tx_byte_rdy !== 1'b0) begin
            failures++;
            $display("FAIL single_push count=%0d empty=%b rdy=%b required count=1 empty=0 rdy=0",
                     o_count, o_empty, o_tx_byte_rdy);
        end
        @(negedge clk);
        i_wr_en = 1'b0;
        @(posedge clk);
        #2;
        stray_done = 1'b1;
        checks++;
        if (o_tx_byte_rdy !== 1'b1 || o_tx_byte !== 8'hAB || o_count !== 5'd0) begin
            failures++;
            $display("FAIL single_issue rdy=%b byte=%h count=%0d required rdy=1 byte=ab count=0",
                     o_tx_byte_rdy, o_tx_byte, o_count);
        end
        @(posedge clk);
        #2;
        stray_done = 1'b0;
        checks++;
        if (o_tx_byte_rdy !== 1'b0 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL single_pulse_width rdy=%b busy=%b required rdy=0 busy=1", o_tx_byte_rdy, o_busy);
        end
        wait_quiet(100, ok);
        checks++;
        if (!ok || rx_q.size() != 1 || rx_q[0] !== 8'hAB) begin
            failures++;
            $display("FAIL single_result quiet=%b frames=%0d required quiet=1 frames=1 byte=ab", ok, rx_q.size());
        end
    endtask

    task automatic test_burst();
        bit ok;
        rx_q.delete();
        frame_lo = 1; frame_hi = 6;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            i_wr_en = 1'b1; i_wr_byte = 8'(i);
        end
        @(negedge clk);
        i_wr_en = 1'b0;
        wait_quiet(300, ok);
        checks++;
        if (!ok || rx_q.size() != 5) begin
            failures++;
            $display("FAIL burst_frames quiet=%b actual=%0d required=5", ok, rx_q.size());
        end
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== 8'(i + 1)) begin
                failures++;
                $display("FAIL burst_order idx=%0d actual=%h required=%h", i, rx_q[i], 8'(i + 1));
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        rx_q.delete();
        frame_lo = 2; frame_hi = 5;
        hold_done = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            i_wr_en = 1'b1; i_wr_byte = 8'(8'h10 + i);
            @(posedge clk);
            #1;
            if (i == 16) begin
                checks++;
                if (o_full !== 1'b1 || o_count !== 5'd16 || o_overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_fill full=%b count=%0d ovf=%b required full=1 count=16 ovf=0",
                             o_full, o_count, o_overflow);
                end
            end
            if (i == 17) begin
                checks++;
                if (o_full !== 1'b1 || o_count !== 5'd16 || o_overflow !== 1'b1) begin
                    failures++;
                    $display("FAIL ovf_drop full=%b count=%0d ovf=%b required full=1 count=16 ovf=1",
                             o_full, o_count, o_overflow);
                end
            end
        end
        @(negedge clk);
        i_wr_en = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (o_overflow !== 1'b0 || o_count !== 5'd16) begin
            failures++;
            $display("FAIL ovf_pulse ovf=%b count=%0d required ovf=0 count=16", o_overflow, o_count);
        end
        hold_done = 1'b0;
        wait_quiet(1000, ok);
        checks++;
        if (!ok || rx_q.size() != 17) begin
            failures++;
            $display("FAIL ovf_frames quiet=%b actual=%0d required=17", ok, rx_q.size());
        end
        for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== 8'(8'h10 + i)) begin
                failures++;
                $display("FAIL ovf_order idx=%0d actual=%h required=%h", i, rx_q[i], 8'(8'h10 + i));
            end
        end
    endtask

    task automatic test_stream_wrap();
        logic [7:0] sent[$];
        logic [7:0] b;
        logic [DEPTH_LOG2:0] saved;
        bit ok, got;
        rx_q.delete();
        coin_cnt = 0;
        frame_lo = 1; frame_hi = 6;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            sent.push_back(b);
            @(negedge clk);
            i_wr_en = 1'b1; i_wr_byte = b;
        end
        @(negedge clk);
        i_wr_en = 1'b0;
        for (int n = 3; n < 40; n++) begin
            got = 1'b0;
            for (int c = 0; c < 50; c++) begin
                @(posedge clk);
                #1;
                if (i_tx_done === 1'b1) begin
                    got = 1'b1;
                    break;
                end
            end
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL stream_done_timeout n=%0d actual=none required=tx_done", n);
                break;
            end
            saved = o_count;
            b = 8'($urandom);
            sent.push_back(b);
            @(negedge clk);
            i_wr_en = 1'b1; i_wr_byte = b;
            @(posedge clk);
            #1;
            checks++;
            if (o_count !== saved || o_tx_byte_rdy !== 1'b1) begin
                failures++;
                $display("FAIL stream_coincident n=%0d count=%0d rdy=%b required count=%0d rdy=1",
                         n, o_count, o_tx_byte_rdy, saved);
            end
            @(negedge clk);
            i_wr_en = 1'b0;
        end
        wait_quiet(500, ok);
        checks++;
        if (!ok || rx_q.size() != sent.size() || coin_cnt < 37) begin
            failures++;
            $display("FAIL stream_result quiet=%b frames=%0d coincident=%0d required frames=%0d coincident>=37",
                     ok, rx_q.size(), coin_cnt, sent.size());
        end
        for (int i = 0; i < sent.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== sent[i]) begin
                failures++;
                $display("FAIL stream_order idx=%0d actual=%h required=%h", i, rx_q[i], sent[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok, got;
        rx_q.delete();
        frame_lo = 6; frame_hi = 6;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            i_wr_en = 1'b1; i_wr_byte = 8'(8'h50 + i);
        end
        @(negedge clk);
        i_wr_en = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (rx_q.size() >= 2) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL rmid_second_frame actual=%0d required=2", rx_q.size());
        end
        @(posedge clk);
        @(negedge clk);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({o_count, o_empty, o_full, o_tx_byte_rdy, o_busy, o_tx_byte} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL rmid_reset count=%0d empty=%b full=%b rdy=%b busy=%b byte=%h required 0/1/0/0/0/00",
                     o_count, o_empty, o_full, o_tx_byte_rdy, o_busy, o_tx_byte);
        end
        @(negedge clk);
        i_rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (rx_q.size() != 2 || o_busy !== 1'b0 || o_count !== 5'd0 || done_cnt != 0) begin
            failures++;
            $display("FAIL rmid_quiet frames=%0d busy=%b count=%0d uart_pending=%0d required 2/0/0/0",
                     rx_q.size(), o_busy, o_count, done_cnt);
        end
        @(negedge clk);
        i_wr_en = 1'b1; i_wr_byte = 8'h3F;
        @(negedge clk);
        i_wr_en = 1'b0;
        wait_quiet(100, ok);
        checks++;
        if (!ok || rx_q.size() != 3 || rx_q[rx_q.size() - 1] !== 8'h3F) begin
            failures++;
            $display("FAIL rmid_new_push quiet=%b frames=%0d required quiet=1 frames=3 last=3f", ok, rx_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_wr_en = 1'b0; i_wr_byte = 8'h00;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_stream_wrap();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
